seq_gen_dual: RTL and testbench
===============================

# seq_gen_dual

Parametrised two-phase sequence generator: the successor to the fixed 6-bit lab sequence counter. UP phase produces a Recamán-style walk (subtract the step index if the result stays positive, otherwise add it); on overflow it switches to a DOWN phase that subtracts successive powers of two until it reaches zero, then restarts UP. It adds width generalisation, an advance enable, a parallel load and a phase-turn pulse. It feeds the lab display/LED output stage directly.

## Interface
- `WIDTH`, default 6: bit width of the sequence value; MAX = 2^WIDTH − 1.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  advance one sequence step this cycle.
- `load`  in  1  load `load_val` and restart the UP phase.
- `load_val`  in  WIDTH  value loaded on `load`.
- `out`  out  WIDTH  current sequence value (registered).
- `mode`  out  1  0 = UP phase, 1 = DOWN phase.
- `idx`  out  WIDTH+1  current UP step index k.
- `turn`  out  1  one-cycle pulse on any phase change or restart.

## Operation
- Internal state: value a (= `out`), index k (WIDTH+1 bits), shift count d (⌈log2(WIDTH+1)⌉ bits), mode.
- Priority: `rst` > `load` > `en`. With none asserted, all state holds and `turn`=0.
- `load`: a←load_val, k←1, d←0, mode←UP, turn←0.
- UP step (`en`, mode=0):
  - If a > k: a←a−k, k←k+1.
  - Else if a+k ≤ MAX (compute in WIDTH+1 bits): a←a+k, k←k+1.
  - Else (overflow): a holds, mode←DOWN, d←0, turn←1 (when SEQ_GEN_DOWN_EN is defined).
- DOWN step (`en`, mode=1), s = 2^d:
  - If a ≥ s: a←a−s, d←d+1. If the result is 0: mode←UP, k←1, turn←1.
  - Else (a < s): a←0, mode←UP, k←1, turn←1.
- Comparisons are unsigned. Ties (a == k) take the add branch.
- k never exceeds MAX+1. Overflow is guaranteed before k exceeds MAX+1.

## Timing
- Reset values: out=0, mode=0, idx=1, turn=0, d=0.
- Latency: one cycle. The new `out`/`mode`/`idx` are visible on the edge after the `en`/`load` sample.
- `turn` is high for exactly the cycle following the transition edge. It is cleared on any cycle without a transition, including `en`=0.
- Reset mid-DOWN or mid-UP: state is fully reinitialised on the next edge. No residual `turn`.
- `load` coincident with the overflow condition: `load` wins; no `turn`.

## Configuration
- `SEQ_GEN_DOWN_EN` defined: DOWN phase is implemented as described.
- Not defined: the DOWN logic and `d` are removed and `mode` is tied to 0. UP overflow instead sets a←0, k←1 and turn←1 (wrap restart).

## Test plan
- Reset, `en`=1 continuously, WIDTH=6 → out = 1,3,6,2,7,1,8,16,7,17 on successive cycles; idx = 2..11; mode=0; turn=0.
- `en` toggled 1,0,0,1 from reset → out = 1,1,1,3; idx holds at 2 during the gap.
- WIDTH=2, SEQ_GEN_DOWN_EN defined, `en`=1 → out 1,3,3,2,0,1. mode = 0,0,1,1,0,0. turn pulses after the 3rd and 5th steps. idx back to 1 after the return to 0.
- WIDTH=2, macro undefined → out 1,3,0,1,3,0. turn pulses on each 0; mode is always 0.
- `load`=1 with `load_val`=60, `en`=1 at the same time, then `en` only (WIDTH=6) → out 60, then 59,57,54. Finally `rst` asserted mid-run → out=0 and idx=1 on the next edge.

Source files
------------

// File: rtl/seq_gen_dual.sv
// Two-phase sequence generator: Recaman-style UP walk; on overflow, a DOWN walk by powers of two back to zero.
// Build macro SEQ_GEN_DOWN_EN enables the DOWN phase; without it, UP overflow wraps and restarts at zero.
module seq_gen_dual #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             mode,
  output logic [WIDTH:0]   idx,
  output logic             turn
);

  localparam logic [WIDTH:0] MAX_W = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   k_q, k_d;
  logic             turn_q, turn_d;
  logic [WIDTH:0]   sum;

  // a <= MAX and k <= MAX+1, so a+k always fits in WIDTH+1 bits.
  assign sum = {1'b0, a_q} + k_q;

`ifdef SEQ_GEN_DOWN_EN
  localparam int DW = $clog2(WIDTH + 1);

  typedef enum logic {
    PH_UP   = 1'b0,
    PH_DOWN = 1'b1
  } phase_e;

  phase_e          mode_q, mode_d;
  logic [DW-1:0]   d_q, d_d;
  logic [WIDTH:0]  s;
  logic [WIDTH:0]  diff;

  // d never exceeds WIDTH, so 2^d fits in WIDTH+1 bits.
  assign s    = {{WIDTH{1'b0}}, 1'b1} << d_q;
  assign diff = {1'b0, a_q} - s;

  always_comb begin
    a_d    = a_q;
    k_d    = k_q;
    d_d    = d_q;
    mode_d = mode_q;
    turn_d = 1'b0;
    if (load) begin
      a_d    = load_val;
      k_d    = {{WIDTH{1'b0}}, 1'b1};
      d_d    = '0;
      mode_d = PH_UP;
    end else if (en) begin
      if (mode_q == PH_UP) begin
        if ({1'b0, a_q} > k_q) begin
          a_d = a_q - k_q[WIDTH-1:0];
          k_d = k_q + 1'b1;
        end else if (sum <= MAX_W) begin
          a_d = sum[WIDTH-1:0];
          k_d = k_q + 1'b1;
        end else begin
          mode_d = PH_DOWN;
          d_d    = '0;
          turn_d = 1'b1;
        end
      end else begin
        if ({1'b0, a_q} >= s) begin
          a_d = diff[WIDTH-1:0];
          d_d = d_q + 1'b1;
          if (diff == '0) begin
            mode_d = PH_UP;
            k_d    = {{WIDTH{1'b0}}, 1'b1};
            turn_d = 1'b1;
          end
        end else begin
          a_d    = '0;
          mode_d = PH_UP;
          k_d    = {{WIDTH{1'b0}}, 1'b1};
          turn_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= PH_UP;
      d_q    <= '0;
    end else begin
      mode_q <= mode_d;
      d_q    <= d_d;
    end
  end

  assign mode = mode_q;
`else
  always_comb begin
    a_d    = a_q;
    k_d    = k_q;
    turn_d = 1'b0;
    if (load) begin
      a_d = load_val;
      k_d = {{WIDTH{1'b0}}, 1'b1};
    end else if (en) begin
      if ({1'b0, a_q} > k_q) begin
        a_d = a_q - k_q[WIDTH-1:0];
        k_d = k_q + 1'b1;
      end else if (sum <= MAX_W) begin
        a_d = sum[WIDTH-1:0];
        k_d = k_q + 1'b1;
      end else begin
        a_d    = '0;
        k_d    = {{WIDTH{1'b0}}, 1'b1};
        turn_d = 1'b1;
      end
    end
  end

  assign mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      k_q    <= {{WIDTH{1'b0}}, 1'b1};
      turn_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      k_q    <= k_d;
      turn_q <= turn_d;
    end
  end

  assign out  = a_q;
  assign idx  = k_q;
  assign turn = turn_q;

endmodule

// File: tb/tb_seq_gen_dual.sv
// Directed-vector bench for seq_gen_dual: a WIDTH=6 instance and a WIDTH=2 instance share one clock.
module tb_seq_gen_dual;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst6 = 1'b0, en6 = 1'b0, load6 = 1'b0;
  logic [5:0] lv6 = '0, out6;
  logic [6:0] idx6;
  logic       mode6, turn6;

  logic       rst2 = 1'b0, en2 = 1'b0, load2 = 1'b0;
  logic [1:0] lv2 = '0, out2;
  logic [2:0] idx2;
  logic       mode2, turn2;

  seq_gen_dual #(.WIDTH(6)) u_w6 (
    .clk(clk), .rst(rst6), .en(en6), .load(load6), .load_val(lv6),
    .out(out6), .mode(mode6), .idx(idx6), .turn(turn6)
  );

  seq_gen_dual #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst2), .en(en2), .load(load2), .load_val(lv2),
    .out(out2), .mode(mode2), .idx(idx2), .turn(turn2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit       sel;    // 0 = WIDTH 6 instance, 1 = WIDTH 2 instance
    bit       rst;
    bit       load;
    bit [5:0] lv;
    bit       en;
    bit [5:0] e_out;
    bit [6:0] e_idx;
    bit       e_mode;
    bit       e_turn;
  } vec_t;

  vec_t vt[$];

  function automatic void v(bit sel, bit r, bit ld, bit [5:0] lv, bit e,
                            bit [5:0] eo, bit [6:0] ei, bit em, bit et);
    vec_t x;
    x.sel = sel; x.rst = r; x.load = ld; x.lv = lv; x.en = e;
    x.e_out = eo; x.e_idx = ei; x.e_mode = em; x.e_turn = et;
    vt.push_back(x);
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input bit sel, input bit r, input bit ld, input bit [5:0] lv, input bit e);
    @(negedge clk);
    rst6 = 1'b0; en6 = 1'b0; load6 = 1'b0; lv6 = '0;
    rst2 = 1'b0; en2 = 1'b0; load2 = 1'b0; lv2 = '0;
    if (!sel) begin
      rst6 = r; load6 = ld; lv6 = lv; en6 = e;
    end else begin
      rst2 = r; load2 = ld; lv2 = lv[1:0]; en2 = e;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int step, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, step, act, exp);
    end
  endtask

  task automatic check_all(input int step, input bit sel, input bit [5:0] eo,
                           input bit [6:0] ei, input bit em, input bit et);
    if (!sel) begin
      chk("w6_out",  step, {1'b0, out6}, {1'b0, eo});
      chk("w6_idx",  step, idx6, ei);
      chk("w6_mode", step, {6'd0, mode6}, {6'd0, em});
      chk("w6_turn", step, {6'd0, turn6}, {6'd0, et});
    end else begin
      chk("w2_out",  step, {5'd0, out2}, {1'b0, eo});
      chk("w2_idx",  step, {4'd0, idx2}, ei);
      chk("w2_mode", step, {6'd0, mode2}, {6'd0, em});
      chk("w2_turn", step, {6'd0, turn2}, {6'd0, et});
    end
  endtask

  initial begin
    // WIDTH 6: reset, continuous walk
    v(0, 1, 0, 0, 0,  0,  1, 0, 0);
    v(0, 0, 0, 0, 1,  1,  2, 0, 0);
    v(0, 0, 0, 0, 1,  3,  3, 0, 0);
    v(0, 0, 0, 0, 1,  6,  4, 0, 0);
    v(0, 0, 0, 0, 1,  2,  5, 0, 0);
    v(0, 0, 0, 0, 1,  7,  6, 0, 0);
    v(0, 0, 0, 0, 1,  1,  7, 0, 0);
    v(0, 0, 0, 0, 1,  8,  8, 0, 0);
    v(0, 0, 0, 0, 1, 16,  9, 0, 0);
    v(0, 0, 0, 0, 1,  7, 10, 0, 0);
    v(0, 0, 0, 0, 1, 17, 11, 0, 0);
    // reset then enable gap 1,0,0,1
    v(0, 1, 0, 0, 0,  0,  1, 0, 0);
    v(0, 0, 0, 0, 1,  1,  2, 0, 0);
    v(0, 0, 0, 0, 0,  1,  2, 0, 0);
    v(0, 0, 0, 0, 0,  1,  2, 0, 0);
    v(0, 0, 0, 0, 1,  3,  3, 0, 0);
    // load wins over en, then descending walk, then reset mid-run
    v(0, 0, 1, 60, 1, 60, 1, 0, 0);
    v(0, 0, 0, 0, 1, 59,  2, 0, 0);
    v(0, 0, 0, 0, 1, 57,  3, 0, 0);
    v(0, 0, 0, 0, 1, 54,  4, 0, 0);
    v(0, 0, 0, 0, 0, 54,  4, 0, 0);
    v(0, 1, 0, 0, 1,  0,  1, 0, 0);
`ifdef SEQ_GEN_DOWN_EN
    // WIDTH 2 with DOWN phase
    v(1, 1, 0, 0, 0, 0, 1, 0, 0);
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 1, 1);
    v(1, 0, 0, 0, 1, 2, 3, 1, 0);
    v(1, 0, 0, 0, 1, 0, 1, 0, 1);
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 0, 0);
    v(1, 0, 1, 2, 1, 2, 1, 0, 0);   // load during overflow condition
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 1, 1);
    v(1, 0, 0, 0, 0, 3, 3, 1, 0);   // turn clears on idle
    v(1, 1, 0, 0, 1, 0, 1, 0, 0);   // reset mid-DOWN
`else
    // WIDTH 2 with wrap restart
    v(1, 1, 0, 0, 0, 0, 1, 0, 0);
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 0, 0);
    v(1, 0, 0, 0, 1, 0, 1, 0, 1);
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 0, 0);
    v(1, 0, 0, 0, 1, 0, 1, 0, 1);
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 0, 0);
    v(1, 0, 1, 2, 1, 2, 1, 0, 0);   // load during overflow condition
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 0, 0, 0, 1, 3, 3, 0, 0);
    v(1, 0, 0, 0, 1, 0, 1, 0, 1);
    v(1, 0, 0, 0, 0, 0, 1, 0, 0);   // turn clears on idle
    v(1, 0, 0, 0, 1, 1, 2, 0, 0);
    v(1, 1, 0, 0, 1, 0, 1, 0, 0);   // reset mid-UP
`endif

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].sel, vt[i].rst, vt[i].load, vt[i].lv, vt[i].en);
      check_all(i, vt[i].sel, vt[i].e_out, vt[i].e_idx, vt[i].e_mode, vt[i].e_turn);
    end

    // Hand sequence: load 1 on WIDTH 2 overflows at a=2, exercising the a < 2^d exit.
    apply(1, 0, 1, 1, 0);
    check_all(100, 1, 1, 1, 0, 0);
    apply(1, 0, 0, 0, 1);
    check_all(101, 1, 2, 2, 0, 0);
`ifdef SEQ_GEN_DOWN_EN
    apply(1, 0, 0, 0, 1);
    check_all(102, 1, 2, 2, 1, 1);
    apply(1, 0, 0, 0, 1);
    check_all(103, 1, 1, 2, 1, 0);
    apply(1, 0, 0, 0, 1);
    check_all(104, 1, 0, 1, 0, 1);
`else
    apply(1, 0, 0, 0, 1);
    check_all(102, 1, 0, 1, 0, 1);
`endif
    apply(1, 0, 0, 0, 0);
    check_all(110, 1, 0, 1, 0, 0);

    // Hand sequence: load holds through idle cycles on WIDTH 6, then one step.
    apply(0, 0, 1, 63, 0);
    check_all(200, 0, 63, 1, 0, 0);
    apply(0, 0, 0, 0, 0);
    check_all(201, 0, 63, 1, 0, 0);
    apply(0, 0, 0, 0, 1);
    check_all(202, 0, 62, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
